// File: rtl/expand_pkg.sv
// expand_pkg: shared definitions for the expand_pack_queue packer.
//   out_state_t  - output register state (EMPTY / FULL)
//   lane_cnt_w   - width needed to count 0..max lanes
//   lane_base    - bit offset of lane k in a word of max lanes
package expand_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  function automatic int lane_cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

  // With msb_first set, lane 0 occupies the top slice of the word.
  function automatic int lane_base(input int k, input int max, input bit msb_first,
                                   input int width);
    return msb_first ? (max - 1 - k) * width : k * width;
  endfunction

endpackage

// File: rtl/expand_pack_queue.sv
// expand_pack_queue: narrow-to-wide stream packer.
// Collects IN_WIDTH beats into OUT_WIDTH words of MAX = OUT_WIDTH/IN_WIDTH lanes.
// A word is emitted when it is full or when last_in marks the end of a packet;
// a completing beat can reload the output register in the same cycle the
// previous word is taken, so input throughput is one beat per cycle.
//
// Optional build macro: EXPAND_PACK_MSB_FIRST_EN
//   defined   - first beat of a word lands in the top lane
//   undefined - first beat lands in the bottom lane
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high
//   din           input beat
//   vld_in        input valid
//   last_in       final beat of a packet (qualified by vld_in)
//   rdy_upward    input ready
//   dout          packed word (registered)
//   vld_out       output valid (registered)
//   last_out      word holds a packet's final beat
//   lanes_out     number of valid lanes in dout
//   rdy_downward  output ready
//
// state | meaning
// EMPTY | output register holds no word
// FULL  | output register holds a word awaiting rdy_downward
module expand_pack_queue
  import expand_pkg::*;
#(
  parameter  int IN_WIDTH  = 32,
  parameter  int OUT_WIDTH = 64,
  localparam int MAX       = OUT_WIDTH / IN_WIDTH,
  localparam int CNT_W     = lane_cnt_w(OUT_WIDTH / IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 vld_in,
  input  logic                 last_in,
  output logic                 rdy_upward,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 vld_out,
  output logic                 last_out,
  output logic [CNT_W-1:0]     lanes_out,
  input  logic                 rdy_downward
);

  generate
    if (MAX < 2 || (OUT_WIDTH % IN_WIDTH) != 0) begin : g_bad_cfg
      $error("expand_pack_queue: OUT_WIDTH must be a multiple >= 2 of IN_WIDTH");
    end
  endgenerate

`ifdef EXPAND_PACK_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  out_state_t           state;
  out_state_t           state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] merged;
  logic                 accept;
  logic                 last_lane;
  logic                 complete;

  assign vld_out    = (state == FULL);
  assign rdy_upward = !reset && (!vld_out || rdy_downward);
  assign accept     = vld_in && rdy_upward;
  assign last_lane  = (cnt == CNT_W'(MAX - 1));
  assign complete   = accept && (last_lane || last_in);

  // acc keeps unfilled lanes at zero, so OR-ing the shifted beat is a lane write.
  always_comb begin
    merged = acc | (OUT_WIDTH'(din) << lane_base(int'(cnt), MAX, MSB_FIRST, IN_WIDTH));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (complete) state_nxt = FULL;
      FULL:  if (rdy_downward && !complete) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      dout      <= '0;
      lanes_out <= '0;
      last_out  <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (complete) begin
          dout      <= merged;
          lanes_out <= cnt + 1'b1;
          last_out  <= last_in;
          cnt       <= '0;
          acc       <= '0;
        end else begin
          acc <= merged;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_expand_pack_queue.sv
module tb_expand_pack_queue;

`ifdef EXPAND_PACK_MSB_FIRST_EN
  localparam logic [63:0]  E_FR1    = 64'h00000011_00000022;
  localparam logic [63:0]  E_FR2    = 64'h00000033_00000044;
  localparam logic [127:0] E_PART   = 128'h0000000A_0000000B_0000000C_00000000;
  localparam logic [127:0] E_SINGLE = 128'h00000005_00000000_00000000_00000000;
  localparam logic [127:0] E_SECOND = 128'h00000006_00000007_00000000_00000000;
  localparam logic [127:0] E_FULL4  = 128'h00000001_00000002_00000003_00000004;
  localparam logic [127:0] E_ORDER  = 128'h00000001_00000002_00000000_00000000;
  localparam int           B2B_SH   = 96;
`else
  localparam logic [63:0]  E_FR1    = 64'h00000022_00000011;
  localparam logic [63:0]  E_FR2    = 64'h00000044_00000033;
  localparam logic [127:0] E_PART   = 128'h00000000_0000000C_0000000B_0000000A;
  localparam logic [127:0] E_SINGLE = 128'h00000000_00000000_00000000_00000005;
  localparam logic [127:0] E_SECOND = 128'h00000000_00000000_00000007_00000006;
  localparam logic [127:0] E_FULL4  = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] E_ORDER  = 128'h00000000_00000000_00000002_00000001;
  localparam int           B2B_SH   = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [31:0] din_a = '0;
  logic        vld_a = 1'b0, last_a = 1'b0, rdn_a = 1'b1;
  logic        rup_a, vout_a, lout_a;
  logic [63:0] dout_a;
  logic [1:0]  lanes_a;

  logic [31:0]  din_b = '0;
  logic         vld_b = 1'b0, last_b = 1'b0, rdn_b = 1'b1;
  logic         rup_b, vout_b, lout_b;
  logic [127:0] dout_b;
  logic [2:0]   lanes_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  expand_pack_queue #(.IN_WIDTH(32), .OUT_WIDTH(64)) u_a (
    .clk(clk), .reset(reset), .din(din_a), .vld_in(vld_a), .last_in(last_a),
    .rdy_upward(rup_a), .dout(dout_a), .vld_out(vout_a), .last_out(lout_a),
    .lanes_out(lanes_a), .rdy_downward(rdn_a));

  expand_pack_queue #(.IN_WIDTH(32), .OUT_WIDTH(128)) u_b (
    .clk(clk), .reset(reset), .din(din_b), .vld_in(vld_b), .last_in(last_b),
    .rdy_upward(rup_b), .dout(dout_b), .vld_out(vout_b), .last_out(lout_b),
    .lanes_out(lanes_b), .rdy_downward(rdn_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (rup_a !== 1'b0) begin
      tests_failed++; $display("FAIL reset_rdy: got %b expected 0", rup_a);
    end
    tests_run++;
    if ({vout_a, lout_a, lanes_a, dout_a} !== '0) begin
      tests_failed++; $display("FAIL reset_out64: vld=%b last=%b lanes=%0d dout=%h expected all 0",
                               vout_a, lout_a, lanes_a, dout_a);
    end
    tests_run++;
    if ({vout_b, lout_b, lanes_b, dout_b} !== '0) begin
      tests_failed++; $display("FAIL reset_out128: vld=%b last=%b lanes=%0d dout=%h expected all 0",
                               vout_b, lout_b, lanes_b, dout_b);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (rup_a !== 1'b1 || rup_b !== 1'b1) begin
      tests_failed++; $display("FAIL release_rdy: got %b%b expected 11", rup_a, rup_b);
    end
  endtask

  task automatic test_full_rate();
    logic [31:0] beats [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    rdn_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_a = beats[i]; vld_a = 1'b1; last_a = 1'b0;
      #1;
      tests_run++;
      if (rup_a !== 1'b1) begin
        tests_failed++; $display("FAIL fr_rdy[%0d]: got %b expected 1", i, rup_a);
      end
      tick();
      tests_run++;
      if (vout_a !== (i % 2 == 1)) begin
        tests_failed++; $display("FAIL fr_vld[%0d]: got %b expected %b", i, vout_a, (i % 2 == 1));
      end
      if (i % 2 == 1) begin
        tests_run++;
        if (dout_a !== ((i == 1) ? E_FR1 : E_FR2) || lanes_a !== 2'd2 || lout_a !== 1'b0) begin
          tests_failed++; $display("FAIL fr_word[%0d]: dout=%h lanes=%0d last=%b expected %h 2 0",
                                   i, dout_a, lanes_a, lout_a, (i == 1) ? E_FR1 : E_FR2);
        end
      end
    end
    vld_a = 1'b0;
    tick();
    tests_run++;
    if (vout_a !== 1'b0) begin
      tests_failed++; $display("FAIL fr_drain: vld got %b expected 0", vout_a);
    end
  endtask

  task automatic test_partial_last();
    logic [31:0] beats [3] = '{32'hA, 32'hB, 32'hC};
    for (int i = 0; i < 3; i++) begin
      din_b = beats[i]; vld_b = 1'b1; last_b = (i == 2);
      tick();
      if (i < 2) begin
        tests_run++;
        if (vout_b !== 1'b0) begin
          tests_failed++; $display("FAIL part_early_vld[%0d]: got %b expected 0", i, vout_b);
        end
      end
    end
    vld_b = 1'b0; last_b = 1'b0;
    tests_run++;
    if (vout_b !== 1'b1 || dout_b !== E_PART || lanes_b !== 3'd3 || lout_b !== 1'b1) begin
      tests_failed++; $display("FAIL part_word: vld=%b dout=%h lanes=%0d last=%b expected 1 %h 3 1",
                               vout_b, dout_b, lanes_b, lout_b, E_PART);
    end
    tick();
  endtask

  task automatic test_single_beat();
    din_b = 32'h5; vld_b = 1'b1; last_b = 1'b1;
    tick();
    vld_b = 1'b0; last_b = 1'b0;
    tests_run++;
    if (vout_b !== 1'b1 || dout_b !== E_SINGLE || lanes_b !== 3'd1 || lout_b !== 1'b1) begin
      tests_failed++; $display("FAIL single_word: vld=%b dout=%h lanes=%0d last=%b expected 1 %h 1 1",
                               vout_b, dout_b, lanes_b, lout_b, E_SINGLE);
    end
    tick();
    din_b = 32'h6; vld_b = 1'b1; last_b = 1'b0;
    tick();
    din_b = 32'h7; last_b = 1'b1;
    tick();
    vld_b = 1'b0; last_b = 1'b0;
    tests_run++;
    if (vout_b !== 1'b1 || dout_b !== E_SECOND || lanes_b !== 3'd2 || lout_b !== 1'b1) begin
      tests_failed++; $display("FAIL next_packet: vld=%b dout=%h lanes=%0d last=%b expected 1 %h 2 1",
                               vout_b, dout_b, lanes_b, lout_b, E_SECOND);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rdn_b = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      din_b = 32'(i); vld_b = 1'b1; last_b = 1'b1;
      #1;
      tests_run++;
      if (rup_b !== 1'b1) begin
        tests_failed++; $display("FAIL b2b_rdy[%0d]: got %b expected 1", i, rup_b);
      end
      tick();
      tests_run++;
      if (vout_b !== 1'b1 || dout_b !== (128'(i) << B2B_SH) || lanes_b !== 3'd1) begin
        tests_failed++; $display("FAIL b2b_word[%0d]: vld=%b dout=%h lanes=%0d expected 1 %h 1",
                                 i, vout_b, dout_b, lanes_b, 128'(i) << B2B_SH);
      end
    end
    vld_b = 1'b0; last_b = 1'b0;
    tick();
    tests_run++;
    if (vout_b !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_drain: vld got %b expected 0", vout_b);
    end
  endtask

  task automatic test_backpressure();
    rdn_a = 1'b1;
    din_a = 32'h11; vld_a = 1'b1; last_a = 1'b0;
    tick();
    din_a = 32'h22;
    tick();
    rdn_a = 1'b0;
    din_a = 32'h33;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++;
      if (rup_a !== 1'b0) begin
        tests_failed++; $display("FAIL bp_rdy[%0d]: got %b expected 0", c, rup_a);
      end
      tick();
      tests_run++;
      if (vout_a !== 1'b1 || dout_a !== E_FR1 || lanes_a !== 2'd2) begin
        tests_failed++; $display("FAIL bp_hold[%0d]: vld=%b dout=%h lanes=%0d expected 1 %h 2",
                                 c, vout_a, dout_a, lanes_a, E_FR1);
      end
    end
    rdn_a = 1'b1;
    tick();
    tests_run++;
    if (vout_a !== 1'b0) begin
      tests_failed++; $display("FAIL bp_release: vld got %b expected 0", vout_a);
    end
    din_a = 32'h44;
    tick();
    vld_a = 1'b0;
    tests_run++;
    if (vout_a !== 1'b1 || dout_a !== E_FR2 || lanes_a !== 2'd2 || lout_a !== 1'b0) begin
      tests_failed++; $display("FAIL bp_second: vld=%b dout=%h lanes=%0d last=%b expected 1 %h 2 0",
                               vout_a, dout_a, lanes_a, lout_a, E_FR2);
    end
    tick();
  endtask

  task automatic test_reset_mid_word();
    din_b = 32'hDEAD; vld_b = 1'b1; last_b = 1'b0;
    tick();
    vld_b = 1'b0;
    reset = 1'b1;
    tick();
    tests_run++;
    if ({vout_b, lout_b, lanes_b, dout_b} !== '0) begin
      tests_failed++; $display("FAIL midrst_out: vld=%b last=%b lanes=%0d dout=%h expected all 0",
                               vout_b, lout_b, lanes_b, dout_b);
    end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      din_b = 32'(i); vld_b = 1'b1;
      tick();
    end
    vld_b = 1'b0;
    tests_run++;
    if (vout_b !== 1'b1 || dout_b !== E_FULL4 || lanes_b !== 3'd4 || lout_b !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_word: vld=%b dout=%h lanes=%0d last=%b expected 1 %h 4 0",
                               vout_b, dout_b, lanes_b, lout_b, E_FULL4);
    end
    tick();
  endtask

  task automatic test_lane_order();
    din_b = 32'h1; vld_b = 1'b1; last_b = 1'b0;
    tick();
    din_b = 32'h2; last_b = 1'b1;
    tick();
    vld_b = 1'b0; last_b = 1'b0;
    tests_run++;
    if (vout_b !== 1'b1 || dout_b !== E_ORDER || lanes_b !== 3'd2 || lout_b !== 1'b1) begin
      tests_failed++; $display("FAIL lane_order: vld=%b dout=%h lanes=%0d last=%b expected 1 %h 2 1",
                               vout_b, dout_b, lanes_b, lout_b, E_ORDER);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_partial_last();
    test_single_beat();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_lane_order();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
